seq_mult_add: RTL and testbench

Sequential shift-and-add multiply-accumulate unit computing `product = multiplicand * multiplier + addend`. It is the inverse of the 4-bit divider: given divisor, quotient and remainder, it reconstructs the dividend. It also flags whether the triple is a legal division result. It sits next to the divider as its checking and reconstruction path, with a single-cycle start/done handshake toward the controlling logic.

---
 rtl/seq_mult_pkg.sv | 8 +
 rtl/seq_mult_add_if.sv | 25 ++
 rtl/seq_mult_add_step.sv | 18 +
 rtl/seq_mult_add.sv | 110 +++++++++++
 tb/tb_seq_mult_add.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the shift-and-add multiply-accumulate unit.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

endpackage

// File: rtl/seq_mult_add_if.sv
// Start/done handshake and operand/result bus between the controller and seq_mult_add.
interface seq_mult_add_if
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   addend;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               rem_valid;

    modport master (
        output start, multiplicand, multiplier, addend,
        input  busy, done, product, rem_valid
    );

    modport slave (
        input  start, multiplicand, multiplier, addend,
        output busy, done, product, rem_valid
    );
endinterface

// File: rtl/seq_mult_add_step.sv
// One shift-and-add iteration: conditionally add the shifted multiplicand into the accumulator.
module mult_step #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic               lsb_i,
    input  logic [CW-1:0]      shamt_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [2*WIDTH-1:0] partial;

    always_comb begin
        partial = {{WIDTH{1'b0}}, mcand_i} << shamt_i;
        acc_o   = lsb_i ? (acc_i + partial) : acc_i;
    end
endmodule

// File: rtl/seq_mult_add.sv
// Reconstructs dividend = divisor * quotient + remainder and flags whether the triple is a legal division result.
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   RUN   | one shift-and-add iteration per clock, WIDTH iterations
//   DONE  | product/rem_valid freshly written, done pulsed for one cycle
module seq_mult_add
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clock,
    input  logic          reset_n,
    seq_mult_add_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] addend_q, addend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic             rem_valid_q, rem_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    acc_step;

    mult_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (mplier_q[0]),
        .shamt_i (cnt_q),
        .acc_o   (acc_step)
    );

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        addend_d    = addend_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        product_d   = product_q;
        rem_valid_d = rem_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    mcand_d  = bus.multiplicand;
                    mplier_d = bus.multiplier;
                    addend_d = bus.addend;
                    acc_d    = {{WIDTH{1'b0}}, bus.addend};
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                // The final iteration's sum goes straight to the output so done and product align.
                if (cnt_q == LAST_ITER) begin
                    state_d     = DONE;
                    product_d   = acc_step;
                    rem_valid_d = (mcand_q != '0) && (addend_q < mcand_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            addend_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            rem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            addend_q    <= addend_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            rem_valid_q <= rem_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.rem_valid = rem_valid_q;
endmodule

// File: tb/tb_seq_mult_add.sv
// Directed and exhaustive checks of seq_mult_add against hand-computed values and an arithmetic reference.
module tb_seq_mult_add;
    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    logic [7:0] last_prod;

    seq_mult_add_if #(.WIDTH(4)) bus ();

    seq_mult_add #(.WIDTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start one operation from idle and check latency, busy length, result and the single done pulse.
    task automatic run_op(input logic [3:0] mc, input logic [3:0] mp, input logic [3:0] ad,
                          input logic [7:0] ep, input logic erv, input string tag);
        int cyc;
        int nbusy;
        @(negedge clock);
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        bus.addend       = ad;
        @(negedge clock);
        bus.start = 1'b0;
        cyc   = 0;
        nbusy = 0;
        while (!bus.done && cyc < 12) begin
            if (bus.busy) nbusy++;
            @(negedge clock);
            cyc++;
        end
        if (bus.busy) nbusy++;
        check_val({tag, "_latency"}, cyc, 4);
        check_val({tag, "_product"}, bus.product, ep);
        check_val({tag, "_rem_valid"}, bus.rem_valid, erv);
        @(negedge clock);
        check_val({tag, "_done_once"}, bus.done, 0);
        check_val({tag, "_busy_len"}, nbusy, 5);
        last_prod = ep;
    endtask

    initial begin
        int cyc;
        int ndone;
        int ep;
        logic [3:0] mc, mp, ad;
        logic [3:0] bb_mc [0:29];
        logic [3:0] bb_mp [0:29];
        logic [3:0] bb_ad [0:29];

        n_tests          = 0;
        n_fail           = 0;
        last_prod        = '0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;

        repeat (2) @(negedge clock);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_product", bus.product, 0);
        check_val("rst_rem_valid", bus.rem_valid, 0);
        reset_n = 1'b1;

        run_op(4'd3,  4'd2,  4'd1,  8'd7,   1'b1, "basic");
        run_op(4'd15, 4'd15, 4'd15, 8'd240, 1'b0, "max");
        run_op(4'd8,  4'd1,  4'd7,  8'd15,  1'b1, "rem_edge");
        run_op(4'd0,  4'd9,  4'd5,  8'd5,   1'b0, "zero_div");
        run_op(4'd4,  4'd0,  4'd3,  8'd3,   1'b1, "zero_quot");

        // start re-pulsed with new operands during the second RUN cycle must be ignored
        @(negedge clock);
        bus.start        = 1'b1;
        bus.multiplicand = 4'd2;
        bus.multiplier   = 4'd3;
        bus.addend       = 4'd0;
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 0;
        @(negedge clock);
        cyc++;
        bus.start        = 1'b1;
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd7;
        bus.addend       = 4'd7;
        @(negedge clock);
        cyc++;
        bus.start = 1'b0;
        while (!bus.done && cyc < 12) begin
            @(negedge clock);
            cyc++;
        end
        check_val("ign_latency", cyc, 4);
        check_val("ign_product", bus.product, 6);
        check_val("ign_rem_valid", bus.rem_valid, 1);
        ndone = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.done) ndone++;
        end
        check_val("ign_no_second_done", ndone, 0);
        check_val("ign_product_hold", bus.product, 6);

        // asynchronous reset in the middle of an operation
        @(negedge clock);
        bus.start        = 1'b1;
        bus.multiplicand = 4'd3;
        bus.multiplier   = 4'd2;
        bus.addend       = 4'd1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_done", bus.done, 0);
        check_val("mid_rst_product", bus.product, 0);
        check_val("mid_rst_rem_valid", bus.rem_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check_val("post_rst_idle", bus.busy, 0);
        check_val("post_rst_no_done", bus.done, 0);
        run_op(4'd5, 4'd3, 4'd2, 8'd17, 1'b1, "after_rst");

        // start held high with operands changing every cycle: accepts at cycles 0,6,12,18,24
        for (int c = 0; c <= 30; c++) begin
            @(negedge clock);
            if (c >= 5 && ((c - 5) % 6) == 0) begin
                ep = int'(bb_mc[c-5]) * int'(bb_mp[c-5]) + int'(bb_ad[c-5]);
                check_val("b2b_done", bus.done, 1);
                check_val("b2b_product", bus.product, ep);
                check_val("b2b_rem_valid", bus.rem_valid,
                          (bb_mc[c-5] != 0 && bb_ad[c-5] < bb_mc[c-5]) ? 1 : 0);
                last_prod = ep[7:0];
            end else begin
                check_val("b2b_no_done", bus.done, 0);
                check_val("b2b_hold", bus.product, last_prod);
            end
            if (c < 30) begin
                bb_mc[c] = 4'((c * 3 + 1) % 16);
                bb_mp[c] = 4'((c * 5 + 2) % 16);
                bb_ad[c] = 4'((c * 7) % 16);
                bus.start        = 1'b1;
                bus.multiplicand = bb_mc[c];
                bus.multiplier   = bb_mp[c];
                bus.addend       = bb_ad[c];
            end else begin
                bus.start = 1'b0;
            end
        end

        for (int i = 0; i < 4096; i++) begin
            mc = 4'(i >> 8);
            mp = 4'(i >> 4);
            ad = 4'(i);
            ep = int'(mc) * int'(mp) + int'(ad);
            run_op(mc, mp, ad, ep[7:0], (mc != 0 && ad < mc), "sweep");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
